cpu_8b: RTL and testbench



---
 rtl/cpu_8b_pkg.sv | 36 +++
 rtl/cpu_8b_if.sv | 31 +++
 rtl/cpu_8b_serial_tx.sv | 43 ++++
 rtl/cpu_8b.sv | 156 +++++++++++++++
 tb/tb_cpu_8b.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_8b_pkg.sv
// rtl/cpu_8b_pkg.sv - shared constants, opcodes and FSM state type for cpu_8b
// Purpose: widths, frame length, opcode encodings, FSM state enum and the
//          helper that slices one byte out of the 128-bit memory image.
// Ports:   none (package).
package cpu_8b_pkg;

    localparam int DATA_W    = 8;
    localparam int ADDR_W    = 4;
    localparam int MEM_DEPTH = 16;
    localparam int FRAME_LEN = 10;   // start + 8 data + stop

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_LDA = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_SUB = 4'h3;
    localparam logic [3:0] OP_STA = 4'h4;
    localparam logic [3:0] OP_LDI = 4'h5;
    localparam logic [3:0] OP_JMP = 4'h6;
    localparam logic [3:0] OP_JC  = 4'h7;
    localparam logic [3:0] OP_JZ  = 4'h8;
    localparam logic [3:0] OP_OUT = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_EXEC  = 2'd1,
        ST_HALT  = 2'd2
    } state_e;

    // Byte n of the reset image lives at bits [8n+7:8n].
    function automatic logic [DATA_W-1:0] prog_byte(input logic [127:0] img,
                                                    input logic [ADDR_W-1:0] idx);
        return img[{idx, 3'b000} +: 8];
    endfunction

endpackage

// File: rtl/cpu_8b_if.sv
// rtl/cpu_8b_if.sv - link between the CPU core and its serial transmitter
// Purpose: groups the transmit handshake (load/data/enable in, busy/serial_out back).
// Ports:   load, data[7:0], enable  core -> transmitter
//          busy, serial_out         transmitter -> core
// Modports: master = core side, slave = transmitter side.
interface cpu_8b_if;
    import cpu_8b_pkg::*;

    logic              load;
    logic [DATA_W-1:0] data;
    logic              enable;
    logic              busy;
    logic              serial_out;

    modport master (
        output load,
        output data,
        output enable,
        input  busy,
        input  serial_out
    );

    modport slave (
        input  load,
        input  data,
        input  enable,
        output busy,
        output serial_out
    );

endinterface

// File: rtl/cpu_8b_serial_tx.sv
// rtl/cpu_8b_serial_tx.sv - 10-bit frame serializer, one bit per enabled clock
// Purpose: on load (when idle) drives the start bit, then 8 data bits LSB first,
//          then the stop bit; the line idles high. enable=0 freezes everything.
// Ports:   clk     clock, rising edge
//          resetn  synchronous active-low reset (overrides enable)
//          tx      cpu_8b_if.slave: load, data, enable in; busy, serial_out out
module cpu_8b_serial_tx
    import cpu_8b_pkg::*;
(
    input  logic      clk,
    input  logic      resetn,
    cpu_8b_if.slave   tx
);

    // shreg_q holds the bits still to be sent after the current one: {stop, data}.
    logic [DATA_W:0] shreg_q;
    logic [3:0]      cnt_q;
    logic            line_q;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            shreg_q <= '1;
            cnt_q   <= '0;
            line_q  <= 1'b1;
        end else if (tx.enable) begin
            if (tx.load && (cnt_q == 4'd0)) begin
                line_q  <= 1'b0;
                shreg_q <= {1'b1, tx.data};
                cnt_q   <= 4'(FRAME_LEN - 1);
            end else if (cnt_q != 4'd0) begin
                line_q  <= shreg_q[0];
                shreg_q <= {1'b1, shreg_q[DATA_W:1]};
                cnt_q   <= cnt_q - 4'd1;
            end
        end
    end

    // Busy drops on the edge that puts the stop bit out, so a load on the
    // following edge yields back-to-back frames.
    assign tx.busy       = (cnt_q != 4'd0);
    assign tx.serial_out = line_q;

endmodule

// File: rtl/cpu_8b.sv
// rtl/cpu_8b.sv - 8-bit accumulator CPU with 16-byte memory and serial output
// Purpose: fetch/execute core over a unified 16x8 memory loaded from PROGRAM at
//          reset; OUT sends the accumulator through cpu_8b_serial_tx.
// Ports:   clock              clock, rising edge
//          input_nclear       synchronous active-low reset (overrides VCC)
//          VCC                run enable; 0 freezes all state
//          output_serial_out  serial transmit line, idle high
module cpu_8b
    import cpu_8b_pkg::*;
#(
    parameter logic [127:0] PROGRAM = 128'h01_00_00_00_00_00_00_00_00_00_00_61_E0_4E_2F_1E
) (
    input  logic clock,
    input  logic input_nclear,
    input  logic VCC,
    output logic output_serial_out
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [DATA_W-1:0] ir_q, ir_d;
    logic [DATA_W-1:0] a_q, a_d;
    logic              c_q, c_d;
    logic              z_q, z_d;
    logic [DATA_W-1:0] mem_q [MEM_DEPTH];

    logic [3:0]        opcode;
    logic [ADDR_W-1:0] operand;
    logic [DATA_W-1:0] instr;
    logic [DATA_W-1:0] mem_op;
    logic [DATA_W:0]   sum;
    logic [DATA_W:0]   diff;

    logic do_fetch;
    logic do_exec;
    logic mem_we;
    logic tx_load;

    cpu_8b_if tx_if ();

    assign opcode  = ir_q[7:4];
    assign operand = ir_q[3:0];
    assign instr   = mem_q[pc_q];
    assign mem_op  = mem_q[operand];
    assign sum     = {1'b0, a_q} + {1'b0, mem_op};
    assign diff    = {1'b0, a_q} - {1'b0, mem_op};

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clock) begin
        if (!input_nclear) begin
            state_q <= ST_FETCH;
        end else if (VCC) begin
            state_q <= state_d;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_FETCH: state_d = ST_EXEC;
            ST_EXEC: begin
                if (opcode == OP_HLT) begin
                    state_d = ST_HALT;
                end else if ((opcode == OP_OUT) && tx_if.busy) begin
                    state_d = ST_EXEC;   // stall until the transmitter frees up
                end else begin
                    state_d = ST_FETCH;
                end
            end
            ST_HALT:  state_d = ST_HALT;
            default:  state_d = ST_FETCH;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        do_fetch = (state_q == ST_FETCH);
        do_exec  = (state_q == ST_EXEC);
        mem_we   = do_exec && (opcode == OP_STA);
        tx_load  = do_exec && (opcode == OP_OUT) && !tx_if.busy;
    end

    // ---------------- datapath next state ----------------
    always_comb begin
        pc_d = pc_q;
        ir_d = ir_q;
        a_d  = a_q;
        c_d  = c_q;
        z_d  = z_q;
        if (do_fetch) begin
            ir_d = instr;
            pc_d = pc_q + 4'd1;
        end else if (do_exec) begin
            case (opcode)
                OP_NOP: ;
                OP_LDA: a_d = mem_op;
                OP_ADD: begin
                    a_d = sum[DATA_W-1:0];
                    c_d = sum[DATA_W];
                    z_d = (sum[DATA_W-1:0] == '0);
                end
                OP_SUB: begin
                    a_d = diff[DATA_W-1:0];
                    c_d = ~diff[DATA_W];   // carry means no borrow
                    z_d = (diff[DATA_W-1:0] == '0);
                end
                OP_STA: ;
                OP_LDI: a_d = {4'b0000, operand};
                OP_JMP: pc_d = operand;
                OP_JC:  if (c_q) pc_d = operand;
                OP_JZ:  if (z_q) pc_d = operand;
                OP_OUT: ;
                OP_HLT: ;
                default: ;
            endcase
        end
    end

    // ---------------- datapath registers and memory ----------------
    always_ff @(posedge clock) begin
        if (!input_nclear) begin
            pc_q <= '0;
            ir_q <= '0;
            a_q  <= '0;
            c_q  <= 1'b0;
            z_q  <= 1'b0;
            for (int i = 0; i < MEM_DEPTH; i++) begin
                mem_q[i] <= prog_byte(PROGRAM, ADDR_W'(i));
            end
        end else if (VCC) begin
            pc_q <= pc_d;
            ir_q <= ir_d;
            a_q  <= a_d;
            c_q  <= c_d;
            z_q  <= z_d;
            if (mem_we) begin
                mem_q[operand] <= a_q;
            end
        end
    end

    // ---------------- transmitter ----------------
    assign tx_if.load   = tx_load;
    assign tx_if.data   = a_q;
    assign tx_if.enable = VCC;

    cpu_8b_serial_tx u_tx (
        .clk    (clock),
        .resetn (input_nclear),
        .tx     (tx_if.slave)
    );

    assign output_serial_out = tx_if.serial_out;

endmodule

// File: tb/tb_cpu_8b.sv
// tb/tb_cpu_8b.sv - scoreboard bench for cpu_8b running three programs side by side
module tb_cpu_8b;

    localparam logic [127:0] PROG_DEF  = 128'h01_00_00_00_00_00_00_00_00_00_00_61_E0_4E_2F_1E;
    localparam logic [127:0] PROG_WRAP = 128'h01_FE_00_00_00_00_00_00_00_00_00_61_E0_4E_2F_1E;
    localparam logic [127:0] PROG_BR   = 128'h03_00_00_00_00_00_00_00_F0_E0_59_F0_E0_85_3F_53;

    logic clock = 1'b0;
    logic input_nclear = 1'b0;
    logic VCC = 1'b1;
    logic out0, out1, out2;
    logic [2:0] lines;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int c0 = 0;
    logic edge_en = 1'b0;
    logic edge_rst = 1'b1;

    logic [7:0] exp_q [3][$];
    int         start_q[$];
    bit         strict [3] = '{1'b0, 1'b0, 1'b1};
    int         bitn   [3] = '{-1, -1, -1};
    logic [7:0] sh     [3];
    logic [7:0] exp_v;

    cpu_8b_if mon_if ();

    cpu_8b #(.PROGRAM(PROG_DEF)) dut0 (
        .clock(clock), .input_nclear(input_nclear), .VCC(VCC), .output_serial_out(out0));
    cpu_8b #(.PROGRAM(PROG_WRAP)) dut1 (
        .clock(clock), .input_nclear(input_nclear), .VCC(VCC), .output_serial_out(out1));
    cpu_8b #(.PROGRAM(PROG_BR)) dut2 (
        .clock(clock), .input_nclear(input_nclear), .VCC(VCC), .output_serial_out(out2));

    assign mon_if.serial_out = out0;
    assign mon_if.load       = 1'b0;
    assign mon_if.data       = 8'h00;
    assign mon_if.enable     = VCC;
    assign mon_if.busy       = 1'b0;
    assign lines = {out2, out1, mon_if.serial_out};

    always #5 clock = ~clock;

    // Remember what the DUTs saw at each rising edge.
    always @(posedge clock) begin
        cyc      <= cyc + 1;
        edge_en  <= VCC;
        edge_rst <= !input_nclear;
    end

    // Monitor: decodes frames, advancing only on edges where the DUT was enabled.
    always @(negedge clock) begin
        for (int i = 0; i < 3; i++) begin
            if (edge_rst) begin
                bitn[i] = -1;
            end else if (edge_en) begin
                if (bitn[i] < 0) begin
                    if (lines[i] == 1'b0) begin
                        bitn[i] = 0;
                        if (i == 0) start_q.push_back(cyc);
                    end
                end else if (bitn[i] < 8) begin
                    sh[i][bitn[i]] = lines[i];
                    bitn[i] = bitn[i] + 1;
                end else begin
                    checks++;
                    if (lines[i] !== 1'b1) begin
                        errors++;
                        $display("FAIL stop_bit inst%0d got %b want 1", i, lines[i]);
                    end
                    if (exp_q[i].size() > 0) begin
                        exp_v = exp_q[i].pop_front();
                        checks++;
                        if (sh[i] !== exp_v) begin
                            errors++;
                            $display("FAIL frame inst%0d got %02h want %02h", i, sh[i], exp_v);
                        end
                    end else if (strict[i]) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_frame inst%0d got %02h want none", i, sh[i]);
                    end
                    bitn[i] = -1;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %0h want %0h", name, got, want);
        end
    endtask

    task automatic reset_all();
        @(negedge clock);
        input_nclear = 1'b0;
        tick();
        tick();
    endtask

    task automatic release_reset();
        input_nclear = 1'b1;
        c0 = cyc;
        start_q.delete();
    endtask

    task automatic flush_exp();
        for (int i = 0; i < 3; i++) exp_q[i].delete();
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n;
        n = 0;
        while ((exp_q[0].size() + exp_q[1].size() + exp_q[2].size()) != 0 && n < budget) begin
            tick();
            n++;
        end
        chk(name, 32'(exp_q[0].size() + exp_q[1].size() + exp_q[2].size()), 32'd0);
    endtask

    logic [9:0] first_bits;
    logic       s_line;
    logic [3:0] s_pc;
    logic [7:0] s_a, s_ir;

    initial begin
        first_bits = 10'b1000000010;   // bit k = line after edge 8+k for frame 0x01

        // ---- reset state and default/wrap/branch programs ----
        reset_all();
        chk("reset_line0", 32'(out0), 32'd1);
        chk("reset_line1", 32'(out1), 32'd1);
        chk("reset_line2", 32'(out2), 32'd1);
        chk("reset_pc",    32'(dut0.pc_q), 32'd0);
        chk("reset_a",     32'(dut0.a_q), 32'd0);
        flush_exp();
        for (int v = 1; v <= 5; v++) exp_q[0].push_back(8'(v));
        exp_q[1].push_back(8'hFF);
        exp_q[1].push_back(8'h00);
        exp_q[1].push_back(8'h01);
        exp_q[2].push_back(8'h09);
        release_reset();
        for (int e = 1; e <= 17; e++) begin
            tick();
            if (e == 4) begin
                chk("wrap_pre_a", 32'(dut1.a_q), 32'hFF);
                chk("wrap_pre_c", 32'(dut1.c_q), 32'd0);
            end
            if (e == 7) chk("idle_before_out", 32'(out0), 32'd1);
            if (e >= 8) chk($sformatf("first_frame_bit%0d", e - 8), 32'(out0), 32'(first_bits[e-8]));
            if (e == 16) begin
                chk("wrap_a", 32'(dut1.a_q), 32'h00);
                chk("wrap_c", 32'(dut1.c_q), 32'd1);
                chk("wrap_z", 32'(dut1.z_q), 32'd1);
            end
        end
        wait_drain("drain_run", 200);
        chk("start_count_ok", 32'(start_q.size() >= 5), 32'd1);
        if (start_q.size() >= 5) begin
            chk("first_start_edge", 32'(start_q[0] - c0), 32'd8);
            for (int k = 0; k < 4; k++)
                chk($sformatf("frame_gap%0d", k), 32'(start_q[k+1] - start_q[k]), 32'd10);
        end

        // ---- VCC freeze mid-frame ----
        reset_all();
        flush_exp();
        exp_q[0].push_back(8'h01);
        exp_q[0].push_back(8'h02);
        exp_q[2].push_back(8'h09);
        release_reset();
        repeat (12) tick();
        VCC    = 1'b0;
        s_line = out0;
        s_pc   = dut0.pc_q;
        s_a    = dut0.a_q;
        s_ir   = dut0.ir_q;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk($sformatf("freeze_line%0d", k), 32'(out0), 32'(s_line));
            chk($sformatf("freeze_pc%0d", k),   32'(dut0.pc_q), 32'(s_pc));
            chk($sformatf("freeze_a%0d", k),    32'(dut0.a_q), 32'(s_a));
            chk($sformatf("freeze_ir%0d", k),   32'(dut0.ir_q), 32'(s_ir));
        end
        VCC = 1'b1;
        wait_drain("drain_freeze", 200);

        // ---- reset mid-frame ----
        reset_all();
        flush_exp();
        release_reset();
        repeat (10) tick();
        chk("midframe_line", 32'(out0), 32'd0);
        chk("midframe_mem14", 32'(dut0.mem_q[14]), 32'd1);
        input_nclear = 1'b0;
        tick();
        chk("rst_line_return", 32'(out0), 32'd1);
        chk("rst_pc", 32'(dut0.pc_q), 32'd0);
        chk("rst_mem14_reload", 32'(dut0.mem_q[14]), 32'd0);
        exp_q[0].push_back(8'h01);
        exp_q[0].push_back(8'h02);
        exp_q[0].push_back(8'h03);
        exp_q[2].push_back(8'h09);
        release_reset();
        wait_drain("drain_restart", 200);

        repeat (30) tick();
        chk("halt_line_idle", 32'(out2), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1);
    end

endmodule
